// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement and flush-on-halt.
// Latency: hits complete combinationally in the request cycle; misses take WORDS (clean) or 2*WORDS (dirty) memory transfers plus one cycle.
// Backpressure: memory dwait holds dREN/dWEN/daddr/dstore and the word counter; the datapath is stalled by keeping dhit low.
module dcache_assoc #(
  parameter int          SETS        = 8,
  parameter int          WAYS        = 2,
  parameter int          WORDS       = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  // Field widths; a WORDS=1 or WAYS=1 field is carried as one constant-zero bit.
  localparam int OFFB  = $clog2(WORDS);
  localparam int OFF_W = (WORDS > 1) ? OFFB : 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = 30 - OFFB - IDX_W;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WB       = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_FLUSH_WB = 3'd4;
  localparam logic [2:0] S_HITCNT   = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  // Line state
  logic             r_valid [SETS][WAYS];
  logic             r_dirty [SETS][WAYS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAY_W-1:0] r_age   [SETS][WAYS];
  logic [31:0]      r_data  [SETS][WAYS][WORDS];

  // Controller state
  logic [2:0]       r_state;
  logic [OFF_W-1:0] r_word;
  logic [WAY_W-1:0] r_vway;
  logic [IDX_W-1:0] r_fset;
  logic [WAY_W-1:0] r_fway;
  logic             r_missed;
  logic [31:0]      r_hitcnt;

  // Request decode
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_hit_any;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_vic_way;
  logic [WAY_W-1:0] w_max_age;
  logic             w_idle_req;
  logic             w_miss;
  logic             w_wr_hit;
  logic             w_fetch_done;
  logic             w_fwb_done;
  logic             w_unused;

  assign w_tag    = dmemaddr[31 -: TAG_W];
  assign w_idx    = dmemaddr[2 + OFFB +: IDX_W];
  assign w_off    = (WORDS > 1) ? dmemaddr[2 +: OFF_W] : '0;
  assign w_unused = &{1'b0, dmemaddr[1:0]};

  // Memory word address of (tag, set, word); the word field vanishes when WORDS=1.
  function automatic logic [31:0] f_addr(input logic [TAG_W-1:0] tag,
                                         input logic [IDX_W-1:0] idx,
                                         input logic [OFF_W-1:0] wrd);
    logic [31:0] a;
    a = {tag, {(32 - TAG_W){1'b0}}};
    a = a | (32'(idx) << (2 + OFFB));
    if (WORDS > 1) a = a | (32'(wrd) << 2);
    return a;
  endfunction

  // Tag lookup across the ways of the addressed set; lowest matching way wins.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, else the oldest way.
  always_comb begin
    w_vic_way = '0;
    w_max_age = r_age[w_idx][0];
    for (int w = 1; w < WAYS; w++) begin
      if (r_age[w_idx][w] > w_max_age) begin
        w_max_age = r_age[w_idx][w];
        w_vic_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_vic_way = WAY_W'(w);
    end
  end

  // halt takes priority over a request in IDLE; reads take priority over writes.
  assign w_idle_req   = (r_state == S_IDLE) && !halt && (dmemREN || dmemWEN);
  assign dhit         = w_idle_req && w_hit_any;
  assign w_miss       = w_idle_req && !w_hit_any;
  assign w_wr_hit     = dhit && !dmemREN;
  assign w_fetch_done = (r_state == S_FETCH) && !dwait && (r_word == LAST_WORD);
  assign w_fwb_done   = (r_state == S_FLUSH_WB) && !dwait && (r_word == LAST_WORD);
  assign flushed      = (r_state == S_DONE);
  assign dmemload     = (dhit && dmemREN) ? r_data[w_idx][w_hit_way][w_off] : 32'd0;

  // Memory port drive; everything is derived from held state so it stays stable under dwait.
  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'd0;
    dstore = 32'd0;
    case (r_state)
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = f_addr(r_tag[w_idx][r_vway], w_idx, r_word);
        dstore = r_data[w_idx][r_vway][r_word];
      end
      S_FETCH: begin
        dREN  = 1'b1;
        daddr = f_addr(w_tag, w_idx, r_word);
      end
      S_FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = f_addr(r_tag[r_fset][r_fway], r_fset, r_word);
        dstore = r_data[r_fset][r_fway][r_word];
      end
      S_HITCNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = r_hitcnt;
      end
      default: ;
    endcase
  end

  // Controller FSM: miss handling, flush scan, hit counter and word sequencing.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_vway   <= '0;
      r_fset   <= '0;
      r_fway   <= '0;
      r_missed <= 1'b0;
      r_hitcnt <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (halt) begin
            r_state <= S_FLUSH;
            r_fset  <= '0;
            r_fway  <= '0;
          end else if (w_miss) begin
            r_vway   <= w_vic_way;
            r_word   <= '0;
            r_missed <= 1'b1;
            r_state  <= (r_valid[w_idx][w_vic_way] && r_dirty[w_idx][w_vic_way]) ? S_WB : S_FETCH;
          end else if (dhit) begin
            if (r_missed) r_missed <= 1'b0;
            else          r_hitcnt <= r_hitcnt + 32'd1;
          end
        end
        S_WB: begin
          if (!dwait) begin
            if (r_word == LAST_WORD) begin
              r_word  <= '0;
              r_state <= S_FETCH;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (!dwait) begin
            if (r_word == LAST_WORD) begin
              r_word  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway]) begin
            r_word  <= '0;
            r_state <= S_FLUSH_WB;
          end else if ((r_fset == LAST_SET) && (r_fway == LAST_WAY)) begin
            r_state <= S_HITCNT;
          end else if (r_fway == LAST_WAY) begin
            r_fway <= '0;
            r_fset <= r_fset + 1'b1;
          end else begin
            r_fway <= r_fway + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          // Once written back the line is clean, so FLUSH moves past it on its next look.
          if (!dwait) begin
            if (r_word == LAST_WORD) begin
              r_word  <= '0;
              r_state <= S_FLUSH;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        S_HITCNT: begin
          if (!dwait) r_state <= S_DONE;
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line metadata: valid/dirty/tag on fill, dirty on write hit or flush, LRU ages on hit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (w_wr_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (dhit && (WAYS > 1)) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_hit_way)
            r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < r_age[w_idx][w_hit_way])
            r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
        end
      end
      if (w_fetch_done) begin
        r_valid[w_idx][r_vway] <= 1'b1;
        r_dirty[w_idx][r_vway] <= 1'b0;
        r_tag[w_idx][r_vway]   <= w_tag;
      end
      if (w_fwb_done) r_dirty[r_fset][r_fway] <= 1'b0;
    end
  end

  // Data array: write hits store the datapath word, fetches capture memory words.
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx][w_hit_way][w_off] <= dmemstore;
    if ((r_state == S_FETCH) && !dwait) r_data[w_idx][r_vway][r_word] <= dload;
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: table of datapath accesses against a word-addressed memory model with programmable wait states.
module tb_dcache_assoc;

  logic        CLK, nRST;
  logic        dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore, dload;

  dcache_assoc #(.SETS(8), .WAYS(2), .WORDS(2), .HITCNT_ADDR(32'h3100)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    int          lat;
    int          cyc;
    logic [31:0] load;
    int          nrd;
    int          nwr;
  } vec_t;

  logic [31:0] mem [0:4095];
  xfer_t       log_q[$];
  int          lat;
  int          m_cnt;
  int          checks, errors;
  logic        p_wait;
  logic [65:0] p_out;
  int          stab_n, stab_bad;

  // Memory model: each transfer completes after lat wait cycles.
  assign dload = mem[daddr[13:2]];
  assign dwait = (dREN || dWEN) && (m_cnt < lat);

  always @(posedge CLK) begin
    if (!(dREN || dWEN)) begin
      m_cnt <= 0;
    end else if (m_cnt >= lat) begin
      m_cnt <= 0;
      if (dWEN) mem[daddr[13:2]] <= dstore;
      log_q.push_back('{we: dWEN, addr: daddr, data: (dWEN ? dstore : dload)});
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Handshake monitor: outputs held while stalled, never read and write together.
  always @(posedge CLK) begin
    if (!nRST) begin
      p_wait <= 1'b0;
    end else begin
      if (p_wait) stab_n <= stab_n + 1;
      if ((p_wait && ({dREN, dWEN, daddr, dstore} != p_out)) || (dREN && dWEN))
        stab_bad <= stab_bad + 1;
      p_wait <= dwait && (dREN || dWEN);
      p_out  <= {dREN, dWEN, daddr, dstore};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One datapath request held until dhit; returns cycles waited and the read data.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input string nm, output int cyc, output logic [31:0] ld);
    @(negedge CLK);
    dmemREN = !wr; dmemWEN = wr; dmemaddr = addr; dmemstore = wd;
    cyc = 0;
    #1;
    while (!dhit && cyc < 300) begin
      @(negedge CLK); #1;
      cyc++;
    end
    chk({nm, "_hit_seen"}, {31'd0, dhit}, 32'd1);
    ld = dmemload;
  endtask

  vec_t  tbl[12];
  int    start_idx[12];
  xfer_t exp_x[5];

  initial begin
    int cyc, n0, nr, nw, n;
    logic [31:0] ld;
    checks = 0; errors = 0; stab_n = 0; stab_bad = 0; m_cnt = 0; lat = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A50000 | 32'(i);

    //            wr    addr        wdata         lat cyc load          rd wr
    tbl[0]  = '{1'b0, 32'h100, 32'h0,        0, 3,  32'hA5A50040, 2, 0};
    tbl[1]  = '{1'b0, 32'h104, 32'h0,        0, 0,  32'hA5A50041, 0, 0};
    tbl[2]  = '{1'b1, 32'h200, 32'hDEAD,     0, 3,  32'h0,        2, 0};
    tbl[3]  = '{1'b0, 32'h200, 32'h0,        0, 0,  32'hDEAD,     0, 0};
    tbl[4]  = '{1'b0, 32'h100, 32'h0,        0, 0,  32'hA5A50040, 0, 0};
    tbl[5]  = '{1'b1, 32'h204, 32'hBEEF,     0, 0,  32'h0,        0, 0};
    tbl[6]  = '{1'b0, 32'h100, 32'h0,        0, 0,  32'hA5A50040, 0, 0};
    tbl[7]  = '{1'b0, 32'h400, 32'h0,        0, 5,  32'hA5A50100, 2, 2};
    tbl[8]  = '{1'b0, 32'h200, 32'h0,        0, 3,  32'hDEAD,     2, 0};
    tbl[9]  = '{1'b1, 32'h048, 32'h11111111, 0, 3,  32'h0,        2, 0};
    tbl[10] = '{1'b1, 32'h400, 32'h22222222, 0, 0,  32'h0,        0, 0};
    tbl[11] = '{1'b0, 32'h088, 32'h0,        5, 13, 32'hA5A50022, 2, 0};

    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    dmemaddr = 32'h0; dmemstore = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ctrl", {28'd0, dhit, flushed, dREN, dWEN}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post_rst_ctrl", {28'd0, dhit, flushed, dREN, dWEN}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      lat = tbl[i].lat;
      start_idx[i] = log_q.size();
      access(tbl[i].wr, tbl[i].addr, tbl[i].wdat, $sformatf("v%0d", i), cyc, ld);
      chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
      if (!tbl[i].wr) chk($sformatf("v%0d_load", i), ld, tbl[i].load);
      nr = 0; nw = 0;
      for (int k = start_idx[i]; k < log_q.size(); k++) begin
        if (log_q[k].we) nw++;
        else nr++;
      end
      chk($sformatf("v%0d_nrd", i), nr, tbl[i].nrd);
      chk($sformatf("v%0d_nwr", i), nw, tbl[i].nwr);
    end

    // LRU eviction of dirty B: both writebacks precede C's fetch.
    exp_x[0] = '{1'b1, 32'h200, 32'hDEAD};
    exp_x[1] = '{1'b1, 32'h204, 32'hBEEF};
    exp_x[2] = '{1'b0, 32'h400, 32'hA5A50100};
    exp_x[3] = '{1'b0, 32'h404, 32'hA5A50101};
    for (int k = 0; k < 4; k++) begin
      n = start_idx[7] + k;
      if (n < log_q.size()) begin
        chk($sformatf("evict%0d_we", k), {31'd0, log_q[n].we}, {31'd0, exp_x[k].we});
        chk($sformatf("evict%0d_addr", k), log_q[n].addr, exp_x[k].addr);
        chk($sformatf("evict%0d_data", k), log_q[n].data, exp_x[k].data);
      end else begin
        chk($sformatf("evict%0d_present", k), n, 32'(log_q.size()));
      end
    end
    chk("mem_wb_0x200", mem[12'h080], 32'hDEAD);
    chk("stable_seen", {31'd0, stab_n > 0}, 32'd1);

    // Halt: flush dirty lines set-major, way-minor, then the hit count (6 counted hits).
    @(negedge CLK);
    lat = 0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b1;
    n0 = log_q.size();
    n = 0;
    #1;
    while (!flushed && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("flushed_set", {31'd0, flushed}, 32'd1);
    exp_x[0] = '{1'b1, 32'h400,  32'h22222222};
    exp_x[1] = '{1'b1, 32'h404,  32'hA5A50101};
    exp_x[2] = '{1'b1, 32'h048,  32'h11111111};
    exp_x[3] = '{1'b1, 32'h04C,  32'hA5A50013};
    exp_x[4] = '{1'b1, 32'h3100, 32'd6};
    chk("flush_xfers", log_q.size() - n0, 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (n0 + k < log_q.size()) begin
        chk($sformatf("flush%0d_we", k), {31'd0, log_q[n0 + k].we}, 32'd1);
        chk($sformatf("flush%0d_addr", k), log_q[n0 + k].addr, exp_x[k].addr);
        chk($sformatf("flush%0d_data", k), log_q[n0 + k].data, exp_x[k].data);
      end
    end
    // DONE ignores a request that would otherwise hit.
    halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h400;
    n0 = log_q.size();
    repeat (3) @(negedge CLK);
    #1;
    chk("done_ctrl", {28'd0, dhit, flushed, dREN, dWEN}, 32'h4);
    chk("done_quiet", log_q.size() - n0, 32'd0);

    // Reset from DONE clears flushed.
    @(negedge CLK);
    nRST = 1'b0; dmemREN = 1'b0;
    #1;
    chk("rst_done_ctrl", {28'd0, dhit, flushed, dREN, dWEN}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Reset in the middle of a stalled fetch.
    lat = 5;
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = 32'h100;
    repeat (4) @(negedge CLK);
    #1;
    chk("mid_fetch_dren", {31'd0, dREN}, 32'd1);
    chk("mid_fetch_addr", daddr, 32'h100);
    #2;
    nRST = 1'b0; dmemREN = 1'b0;
    #1;
    chk("async_rst_ctrl", {28'd0, dhit, flushed, dREN, dWEN}, 32'd0);
    chk("async_rst_daddr", daddr, 32'd0);
    chk("async_rst_dstore", dstore, 32'd0);
    chk("async_rst_load", dmemload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1; lat = 0;
    access(1'b0, 32'h100, 32'h0, "refetch", cyc, ld);
    chk("refetch_cycles", cyc, 32'd3);
    chk("refetch_load", ld, 32'hA5A50040);
    access(1'b0, 32'h104, 32'h0, "rehit", cyc, ld);
    chk("rehit_cycles", cyc, 32'd0);
    chk("rehit_load", ld, 32'hA5A50041);
    @(negedge CLK);
    dmemREN = 1'b0;
    @(negedge CLK);

    chk("handshake_stable", stab_bad, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
